block_mac_2x2: RTL

Signed 2x2 block multiply-accumulate engine. It sits directly downstream of the matrix multiplication control unit. Each accepted start computes C ← C + A·B over 2x2 blocks of data_w-bit two's-complement values. It uses one shared multiplier and one adder, sequenced over eight steps. Results are presented on c_11..c_22, with a one-cycle done_mac pulse that the control unit consumes.

---
 rtl/block_mac_2x2.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/block_mac_2x2.sv
// Signed 2x2 block multiply-accumulate, C <= C + A*B, one shared multiplier over eight steps.
// Define BLOCK_MAC_SAT_EN for saturating product/accumulate; default build wraps modulo 2^data_w.
module block_mac_2x2 #(
  parameter int data_w = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_mac,
  input  logic              acc_clr,
  input  logic [data_w-1:0] a_11,
  input  logic [data_w-1:0] a_12,
  input  logic [data_w-1:0] a_21,
  input  logic [data_w-1:0] a_22,
  input  logic [data_w-1:0] b_11,
  input  logic [data_w-1:0] b_12,
  input  logic [data_w-1:0] b_21,
  input  logic [data_w-1:0] b_22,
  output logic [data_w-1:0] c_11,
  output logic [data_w-1:0] c_12,
  output logic [data_w-1:0] c_21,
  output logic [data_w-1:0] c_22,
  output logic              done_mac,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [data_w-1:0] zero_c = {data_w{1'b0}};
`ifdef BLOCK_MAC_SAT_EN
  localparam logic [data_w-1:0] sat_max_c = {1'b0, {(data_w-1){1'b1}}};
  localparam logic [data_w-1:0] sat_min_c = {1'b1, {(data_w-1){1'b0}}};
  localparam logic signed [2*data_w-1:0] prod_max_c = {{(data_w+1){1'b0}}, {(data_w-1){1'b1}}};
  localparam logic signed [2*data_w-1:0] prod_min_c = {{(data_w+1){1'b1}}, {(data_w-1){1'b0}}};
`endif

  function automatic logic [data_w-1:0] mul_fn(input logic [data_w-1:0] x, input logic [data_w-1:0] y);
`ifdef BLOCK_MAC_SAT_EN
    logic signed [2*data_w-1:0] p;
    p = $signed({{data_w{x[data_w-1]}}, x}) * $signed({{data_w{y[data_w-1]}}, y});
    if (p > prod_max_c) begin
      mul_fn = sat_max_c;
    end else if (p < prod_min_c) begin
      mul_fn = sat_min_c;
    end else begin
      mul_fn = p[data_w-1:0];
    end
`else
    mul_fn = x * y;
`endif
  endfunction

  function automatic logic [data_w-1:0] add_fn(input logic [data_w-1:0] x, input logic [data_w-1:0] y);
`ifdef BLOCK_MAC_SAT_EN
    logic [data_w:0] s;
    // One guard bit: guard and sign disagree exactly on signed overflow.
    s = {x[data_w-1], x} + {y[data_w-1], y};
    if (s[data_w] != s[data_w-1]) begin
      add_fn = s[data_w] ? sat_min_c : sat_max_c;
    end else begin
      add_fn = s[data_w-1:0];
    end
`else
    add_fn = x + y;
`endif
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [data_w-1:0] prod_q, prod_d;
  logic [data_w-1:0] a_q [4];
  logic [data_w-1:0] a_d [4];
  logic [data_w-1:0] b_q [4];
  logic [data_w-1:0] b_d [4];
  logic [data_w-1:0] acc_q [4];
  logic [data_w-1:0] acc_d [4];
  logic [data_w-1:0] c_q [4];
  logic [data_w-1:0] c_d [4];
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              start_prev_q, start_prev_d;
  logic              start_s;
  logic [1:0]        e_s;
  logic [1:0]        ep_s;
  logic              k_s;

  // Element index e = {i,j}; operand index is {i,k} for A and {k,j} for B.
  assign start_s = start_mac & ~start_prev_q;
  assign e_s     = step_q[2:1];
  assign k_s     = step_q[0];
  assign ep_s    = k_s ? e_s : (e_s - 2'd1);

  // Next-state and datapath sequencing
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    prod_d       = prod_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    c_d          = c_q;
    done_d       = 1'b0;
    busy_d       = 1'b0;
    start_prev_d = start_mac;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          a_d[0] = a_11;
          a_d[1] = a_12;
          a_d[2] = a_21;
          a_d[3] = a_22;
          b_d[0] = b_11;
          b_d[1] = b_12;
          b_d[2] = b_21;
          b_d[3] = b_22;
          for (int i = 0; i < 4; i++) begin
            acc_d[i] = acc_clr ? zero_c : c_q[i];
          end
          step_d  = 3'd0;
          busy_d  = 1'b1;
          state_d = S_MUL;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_MUL: begin
        busy_d = 1'b1;
        prod_d = mul_fn(a_q[{e_s[1], k_s}], b_q[{k_s, e_s[0]}]);
        if (step_q != 3'd0) begin
          acc_d[ep_s] = add_fn(acc_q[ep_s], prod_q);
        end else begin
          acc_d = acc_q;
        end
        if (step_q == 3'd7) begin
          state_d = S_DRAIN;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_DRAIN: begin
        busy_d   = 1'b1;
        acc_d[3] = add_fn(acc_q[3], prod_q);
        state_d  = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b1;
        c_d     = acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      step_q       <= 3'd0;
      prod_q       <= zero_c;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      start_prev_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i]   <= zero_c;
        b_q[i]   <= zero_c;
        acc_q[i] <= zero_c;
        c_q[i]   <= zero_c;
      end
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      prod_q       <= prod_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      start_prev_q <= start_prev_d;
      for (int i = 0; i < 4; i++) begin
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
        acc_q[i] <= acc_d[i];
        c_q[i]   <= c_d[i];
      end
    end
  end

  assign c_11     = c_q[0];
  assign c_12     = c_q[1];
  assign c_21     = c_q[2];
  assign c_22     = c_q[3];
  assign done_mac = done_q;
  assign busy     = busy_q;

endmodule
